// File: rtl/clic_ip_gateway_if.sv
// Bundle of the gateway's source, control and pending-bit signals.
// Handshake: ack_valid_i and ip_we_i are single-cycle strobes. Each is acted on
// in the cycle it is high and there is no ready/back-pressure, so the driver
// must present ack_id_i and ip_wdata_i in that same cycle.
interface clic_ip_gateway_if #(
    parameter int N_SOURCE = 32,
    parameter int ID_W     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
);
    logic [N_SOURCE-1:0] intr_src_i;
    logic [N_SOURCE-1:0] le_i;
    logic [N_SOURCE-1:0] pol_i;
    logic [N_SOURCE-1:0] ip_we_i;
    logic [N_SOURCE-1:0] ip_wdata_i;
    logic                ack_valid_i;
    logic [ID_W-1:0]     ack_id_i;
    logic [N_SOURCE-1:0] ip_o;
    logic                ready_o;
    logic                dbg_state_o;   // warm-up FSM state: 0 = warming, 1 = ready

    modport master (
        output intr_src_i, le_i, pol_i, ip_we_i, ip_wdata_i, ack_valid_i, ack_id_i,
        input  ip_o, ready_o, dbg_state_o
    );

    modport slave (
        input  intr_src_i, le_i, pol_i, ip_we_i, ip_wdata_i, ack_valid_i, ack_id_i,
        output ip_o, ready_o, dbg_state_o
    );
endinterface

// File: rtl/clic_ip_gateway.sv
// Per-source CLIC interrupt gateway: synchronises raw lines, applies polarity
// and level/edge mode, latches edge events and clears them on ack or SW write.
module clic_ip_gateway #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    clic_ip_gateway_if.slave gw
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic {
        ST_WARM  = 1'b0,
        ST_READY = 1'b1
    } warm_state_e;

    warm_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_SOURCE-1:0] s, e, ev, ack_hit;
    logic [N_SOURCE-1:0] prev_q, ip_q, ip_d, le_q;
    logic                ready;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = gw.intr_src_i;
        end else begin : g_sync
            logic [N_SOURCE-1:0] sync_q [SYNC_STAGES];

            // Shift raw lines through the synchroniser chain.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= gw.intr_src_i;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Ids at or above N_SOURCE can never match, so out-of-range acks fall away.
    generate
        for (genvar i = 0; i < N_SOURCE; i++) begin : g_ack
            assign ack_hit[i] = gw.ack_valid_i && (gw.ack_id_i == ID_W'(i));
        end
    endgenerate

    assign ready = (state_q == ST_READY);
    assign e     = s ^ gw.pol_i;
    // Edges are masked until the synchroniser has flushed its reset zeros,
    // otherwise active-low sources would fire right after reset.
    assign ev    = {N_SOURCE{ready}} & e & ~prev_q;

    // Warm-up state and cycle counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_WARM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Warm-up: count SYNC_STAGES+1 cycles, then stay ready until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WARM: begin
                if (cnt_q == CNT_W'(SYNC_STAGES)) state_d = ST_READY;
                else                              cnt_d   = cnt_q + 1'b1;
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_WARM;
        endcase
    end

    // Per-source pending next state; a mode switch cycle holds the old value.
    always_comb begin
        ip_d = ip_q;
        for (int i = 0; i < N_SOURCE; i++) begin
            if (gw.le_i[i] != le_q[i]) begin
                ip_d[i] = ip_q[i];
            end else if (gw.le_i[i]) begin
                if (ev[i])               ip_d[i] = 1'b1;   // a new edge is never lost
                else if (gw.ip_we_i[i])  ip_d[i] = gw.ip_wdata_i[i];
                else if (ack_hit[i])     ip_d[i] = 1'b0;
            end else begin
                ip_d[i] = e[i];
            end
        end
    end

    // Pending bits, previous effective level and mode history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_q   <= '0;
            prev_q <= '0;
            le_q   <= '0;
        end else begin
            ip_q   <= ip_d;
            prev_q <= e;
            le_q   <= gw.le_i;
        end
    end

    assign gw.ip_o        = ip_q;
    assign gw.ready_o     = ready;
    assign gw.dbg_state_o = state_q;
endmodule
